// File: rtl/load_mem_unit.sv
// load_mem_unit: single-outstanding load pipeline stage behind the load data
// queue. Issues one word read per load, extracts/extends the addressed
// byte/halfword/word and hands the result to writeback. Misaligned loads skip
// memory and complete with an exception flag.
module load_mem_unit #(
    parameter int LDQ_IDX_W = 4,
    parameter int PREG_W    = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ld_vld_i,
    input  logic [31:0]          ld_addr_i,
    input  logic [LDQ_IDX_W-1:0] ld_ldq_idx_i,
    input  logic [2:0]           ld_funct3_i,
    input  logic [PREG_W-1:0]    ld_prd_i,
    output logic                 ld_rdy_o,
    output logic                 mem_req_vld_o,
    output logic [31:0]          mem_req_addr_o,
    input  logic                 mem_req_rdy_i,
    input  logic                 mem_rsp_vld_i,
    input  logic [31:0]          mem_rsp_data_i,
    output logic                 wb_vld_o,
    output logic [31:0]          wb_data_o,
    output logic [PREG_W-1:0]    wb_prd_o,
    output logic [LDQ_IDX_W-1:0] wb_ldq_idx_o,
    output logic                 wb_misalign_o,
    input  logic                 wb_rdy_i,
    input  logic                 flush_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [31:0]            addr_r;
    logic [2:0]             funct3_r;
    logic [PREG_W-1:0]      prd_r;
    logic [LDQ_IDX_W-1:0]   idx_r;
    logic [31:0]            data_r;
    logic                   misalign_r;
    logic                   accept_s;

    // Size is encoded in funct3[1:0]: 00 byte, 01 half, anything else is
    // handled as a word (this also covers the undefined encodings).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

    // Select the addressed lane and sign/zero extend; funct3[2] set means unsigned.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   res = {{24{~f3[2] & byte_v[7]}}, byte_v};
            2'b01:   res = {{16{~f3[2] & half_v[15]}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    assign ld_rdy_o       = (state_r == ST_IDLE) && !flush_i && !rst_i;
    assign accept_s       = ld_vld_i && ld_rdy_o;
    assign mem_req_vld_o  = (state_r == ST_REQ);
    assign mem_req_addr_o = {addr_r[31:2], 2'b00};
    assign wb_vld_o       = (state_r == ST_WB);
    assign wb_data_o      = data_r;
    assign wb_prd_o       = prd_r;
    assign wb_ldq_idx_o   = idx_r;
    assign wb_misalign_o  = misalign_r;

    // State register; reset drops any in-flight load immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic including flush squash and drain of an issued read.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_misaligned(ld_funct3_i, ld_addr_i[1:0])) begin
                        state_next_s = ST_WB;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    // A request already handed to memory must have its response drained.
                    state_next_s = mem_req_rdy_i ? ST_DRAIN : ST_IDLE;
                end else if (mem_req_rdy_i) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_next_s = mem_rsp_vld_i ? ST_IDLE : ST_DRAIN;
                end else if (mem_rsp_vld_i) begin
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_WB: begin
                if (flush_i || wb_rdy_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_DRAIN: begin
                if (mem_rsp_vld_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Load context captured on accept; result data captured on response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r     <= 32'h0000_0000;
            funct3_r   <= 3'b000;
            prd_r      <= '0;
            idx_r      <= '0;
            data_r     <= 32'h0000_0000;
            misalign_r <= 1'b0;
        end else if (accept_s) begin
            addr_r     <= ld_addr_i;
            funct3_r   <= ld_funct3_i;
            prd_r      <= ld_prd_i;
            idx_r      <= ld_ldq_idx_i;
            data_r     <= 32'h0000_0000;
            misalign_r <= is_misaligned(ld_funct3_i, ld_addr_i[1:0]);
        end else if ((state_r == ST_WAIT) && mem_rsp_vld_i && !flush_i) begin
            data_r     <= extract_load(mem_rsp_data_i, funct3_r, addr_r[1:0]);
        end else begin
            data_r     <= data_r;
        end
    end

endmodule

// File: doc/load_mem_unit.md
Name: load_mem_unit

Overview:
- Sits directly downstream of load_data_queue. Drives its issue_en_i and consumes issue_vld_o/issue_entry_o; the top level unpacks the ldq_entry_t fields onto the ld_* ports.
- Performs one data-memory read per issued load over a valid/ready request and response interface.
- Aligns and sign- or zero-extends the returned word, then presents the result on a writeback handshake.
- Handles one load in flight; misaligned accesses complete without a memory access and are flagged.

Parameters:
LDQ_IDX_W, 4, width of LDQ index ($clog2(LDQ_ENTRIES))
PREG_W, 6, physical destination register tag width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ld_vld_i  in  1  LDQ has an issuable entry (issue_vld_o)
ld_addr_i  in  32  load byte address
ld_ldq_idx_i  in  LDQ_IDX_W  LDQ slot of the load
ld_funct3_i  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ld_prd_i  in  PREG_W  destination physical register
ld_rdy_o  out  1  issue enable to LDQ (issue_en_i)
mem_req_vld_o  out  1  read request valid
mem_req_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_req_rdy_i  in  1  memory accepts request
mem_rsp_vld_i  in  1  read data valid
mem_rsp_data_i  in  32  read word
wb_vld_o  out  1  result valid
wb_data_o  out  32  extended load data
wb_prd_o  out  PREG_W  destination tag
wb_ldq_idx_o  out  LDQ_IDX_W  completing LDQ slot
wb_misalign_o  out  1  misaligned-address exception
wb_rdy_i  in  1  writeback accepts result
flush_i  in  1  squash all in-flight work

Behaviour:
- Reset: state=IDLE. ld_rdy_o=1 after reset (0 during reset). mem_req_vld_o=0, wb_vld_o=0, all data/tag outputs 0.
- FSM states: IDLE, REQ, WAIT, WB, DRAIN.
- ld_rdy_o = (state==IDLE) && !flush_i. Accept occurs when ld_vld_i && ld_rdy_o; addr, funct3, prd and idx are latched on accept.
- Misalignment check on accept: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned: go to WB with wb_misalign_o=1 and wb_data_o=0; no memory request.
  - Otherwise go to REQ.
- REQ: mem_req_vld_o=1, and mem_req_addr_o held stable until mem_req_rdy_i. Handshake transitions to WAIT.
- WAIT: on mem_rsp_vld_i, capture the extracted data and go to WB.
- Extraction uses lane = addr[1:0]:
  - LB/LBU take byte data[8*lane+:8].
  - LH/LHU take data[16*addr[1]+:16].
  - LW takes the whole word.
  - Signed types sign-extend to 32; unsigned types zero-extend.
- WB: wb_vld_o=1 with outputs stable until wb_rdy_i. Handshake returns to IDLE; a new accept is possible the following cycle.
- Latency: accept at cycle N gives mem_req_vld_o at N+1. If the request is accepted at N+1 and the response arrives at M≥N+2, wb_vld_o is asserted at M+1. Best-case accept-to-accept is 4 cycles.
- Undefined funct3 values (011, 11x) are treated as LW.
- Flush handling:
  - Flush in IDLE: blocks accept that cycle.
  - Flush in REQ without handshake that cycle: drop request and go to IDLE.
  - Flush in REQ with handshake the same cycle: go to DRAIN.
  - Flush in WAIT without response: go to DRAIN.
  - Flush in WAIT with response the same cycle: go to IDLE.
  - Flush in WB: drop the result, deassert wb_vld_o, go to IDLE; a same-cycle wb_rdy_i is still ignored for the following cycle.
- DRAIN: ld_rdy_o=0. Wait for mem_rsp_vld_i, discard the data, go to IDLE. Further flushes in DRAIN have no effect.
- Reset mid-operation returns to IDLE immediately. Any outstanding memory response after reset is ignored (it arrives in IDLE, where mem_rsp_vld_i is don't-care).
- mem_rsp_vld_i outside WAIT/DRAIN is ignored.

Test Plan:
- LW: accept addr=0x1000, idx=3, prd=12. mem_req_rdy_i=1 immediately, rsp 0xDEADBEEF two cycles later → mem_req_addr_o=0x1000, wb_data_o=0xDEADBEEF, wb_ldq_idx_o=3, wb_prd_o=12, misalign=0.
- Extraction on rsp word 0x80FF7F01:
  - LB addr 0x2003 → 0xFFFFFF80.
  - LBU addr 0x2001 → 0x0000007F.
  - LH addr 0x2002 → 0xFFFF80FF.
  - LHU addr 0x2000 → 0x00007F01.
  - mem_req_addr_o=0x2000 in every case.
- Misalign: LW at 0x1002 → no mem_req_vld_o. wb_vld_o one cycle after accept with wb_misalign_o=1, wb_data_o=0.
- Backpressure: mem_req_rdy_i low for 3 cycles, then wb_rdy_i low for 2 cycles → address and wb outputs held stable. ld_rdy_o stays 0 until the cycle after the wb handshake.
- Flush in WAIT: flush, then response 4 cycles later → no wb_vld_o, ld_rdy_o=0 until the response, then 1. A following load at 0x3000 completes normally with its own data.
- Back-to-back: two LDQ entries issued with ld_vld_i held high → exactly two wb handshakes in order with correct idx. A reset asserted in WAIT → all outputs 0 the next cycle and ld_rdy_o=1 after reset deasserts.
